hex_debug_display: RTL and testbench
====================================

# hex_debug_display

Downstream consumer of the CPU debug tap on the FPGA board top. It latches a 32-bit debug word, such as a register-file value or the PC, and shows it as eight hex digits on a multiplexed, common-anode seven-segment display. Scanning uses a refresh counter with a blanking interval between digits to prevent ghosting. It runs in the undivided board clock domain, alongside the clock divider that feeds the CPU.

## Interface
Parameters:
- DIGITS, 8: number of scanned digits, 1..8; digit i shows nibble value[4i+3:4i].
- REFRESH_DIV, 100000: clock cycles each digit is driven; must be ≥2.
- BLANK_CYCLES, 2: cycles with all anodes off between digits; must be ≥1.

Ports:
- sysClk  in  1  board clock; all state updates on its rising edge.
- sysRes  in  1  asynchronous, active-low reset.
- value  in  32  debug word to display.
- valueValid  in  1  latch strobe; samples value when high and freeze is low.
- freeze  in  1  holds the displayed word; also lights the DP on digit 0.
- dispValue  out  32  currently latched word.
- anodes  out  DIGITS  active-low digit enables; bit 0 is the rightmost digit.
- segments  out  7  active-low segment lines; bit0=a … bit6=g.
- dp  out  1  active-low decimal point.

## Operation
- Latch:
  - dispValue <= value on any edge where valueValid=1 and freeze=0.
  - If valueValid=1 and freeze=1 in the same cycle, freeze wins and nothing is latched.
- FSM states:
  - SCAN: the refresh counter counts 0..REFRESH_DIV-1. At the terminal count, the counter clears and the FSM moves to BLANK.
  - BLANK: the counter counts 0..BLANK_CYCLES-1. At the terminal count, the counter clears, digit index = (index+1) mod DIGITS, and the FSM moves to SCAN.
- Digit index: wraps from DIGITS-1 to 0, with no skipped or repeated digit.
- Output register (all outputs registered), computed from the previous cycle's state, index and dispValue:
  - In SCAN: anodes has only bit[index] low; segments = hexdecode(nibble[index]); dp = ~(freeze && index==0).
  - In BLANK: anodes all 1, segments 7'h7F, dp 1.
- Hex decode, standard glyphs, active-low, g…a order:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Reset:
  - Asserting sysRes low forces anodes all 1, segments 7'h7F, dp 1, dispValue 0, state SCAN, index 0 and counter 0.
  - These values apply immediately, without waiting for a clock edge, and hold while reset is low.
  - Reset asserted mid-scan or mid-blank aborts the operation in progress; there is no resume.

## Timing
- Reset release: on the first edge after release, internal state is SCAN/index 0. On the second edge, anodes[0]=0 with digit 0 decoded.
- Digit period: REFRESH_DIV cycles lit, then BLANK_CYCLES cycles dark.
- Frame period: DIGITS × (REFRESH_DIV + BLANK_CYCLES) cycles.
- Latency: valueValid sampled at edge k updates dispValue at edge k. segments reflect the new nibble from edge k+1, provided the FSM is in SCAN.
- freeze: takes effect on dp with the same one-cycle registered latency.
- All outputs are glitch-free, since each is a register.

## Configuration
- HEX_DEBUG_DISPLAY_LZB_EN defined (leading-zero blanking):
  - During SCAN, digits above the most significant nonzero nibble of dispValue output segments 7'h7F, while their anode is still driven.
  - Digit 0 is always shown, so value 0 displays a single "0".
- Not defined: every digit is always decoded, including leading zeros.
- The macro has no effect on the FSM, timing, anodes or dp.

## Test plan
All scenarios use DIGITS=8, REFRESH_DIV=4, BLANK_CYCLES=1.
- Reset mid-scan: pull sysRes low while anodes=8'hFD → anodes=8'hFF, segments=7'h7F, dp=1 and dispValue=0 with no clock edge; after release, anodes[0] goes low on the second edge.
- Scan order: free-run 2 frames → anodes[i] low for exactly 4 cycles, all-high for 1 cycle, i steps 0→7→0; frame length is 40 cycles.
- Latch/decode: pulse valueValid with value=32'h0000_00A5 → dispValue=32'hA5; digit 0 segments=7'b0010010, digit 1 segments=7'b0001000, digits 2–7 segments=7'b1000000 (macro off).
- Freeze priority: freeze=1 with valueValid=1 and value=32'h1234 in the same cycle → dispValue unchanged; dp=0 only while digit 0 is lit.
- LZB on: value=32'h0000_00A5 → digits 2–7 segments=7'h7F; value=0 → digit 0 segments=7'b1000000 and the rest 7'h7F.
- Latency: valueValid at edge k during SCAN on digit 0 → dispValue new at k, segments new at k+1.

Source files
------------

// File: rtl/hex_debug_display.sv
// hex_debug_display
//
// Latches a 32-bit debug word and scans it as hex digits onto a multiplexed,
// common-anode seven-segment display. Each digit is lit for REFRESH_DIV cycles,
// followed by BLANK_CYCLES cycles with all anodes off to prevent ghosting.
//
// Ports:
//   sysClk      board clock, rising-edge
//   sysRes      asynchronous active-low reset
//   value       debug word to display
//   valueValid  latch strobe (ignored while freeze is high)
//   freeze      holds the displayed word; lights the DP on digit 0
//   dispValue   currently latched word
//   anodes      active-low digit enables, bit 0 = rightmost digit
//   segments    active-low segments, bit0=a .. bit6=g
//   dp          active-low decimal point
//
// Optional feature: define HEX_DEBUG_DISPLAY_LZB_EN for leading-zero blanking.

module hex_debug_display #(
    parameter int unsigned DIGITS       = 8,
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 2
) (
    input  logic              sysClk,
    input  logic              sysRes,
    input  logic [31:0]       value,
    input  logic              valueValid,
    input  logic              freeze,
    output logic [31:0]       dispValue,
    output logic [DIGITS-1:0] anodes,
    output logic [6:0]        segments,
    output logic              dp
);

    localparam int unsigned IDXW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int unsigned CNTW    = $clog2(CNT_MAX);

    typedef enum logic {
        StScan,
        StBlank
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    // Holds the scan engine for one edge after reset release so digit 0 gets
    // its full lit period starting on the second edge.
    logic              run_q;

    logic [DIGITS-1:0] anodes_d;
    logic [6:0]        segments_d;
    logic              dp_d;
    logic [3:0]        nibble;

    function automatic logic [6:0] hexdecode(input logic [3:0] n);
        case (n)
            4'h0:    hexdecode = 7'b1000000;
            4'h1:    hexdecode = 7'b1111001;
            4'h2:    hexdecode = 7'b0100100;
            4'h3:    hexdecode = 7'b0110000;
            4'h4:    hexdecode = 7'b0011001;
            4'h5:    hexdecode = 7'b0010010;
            4'h6:    hexdecode = 7'b0000010;
            4'h7:    hexdecode = 7'b1111000;
            4'h8:    hexdecode = 7'b0000000;
            4'h9:    hexdecode = 7'b0010000;
            4'hA:    hexdecode = 7'b0001000;
            4'hB:    hexdecode = 7'b0000011;
            4'hC:    hexdecode = 7'b1000110;
            4'hD:    hexdecode = 7'b0100001;
            4'hE:    hexdecode = 7'b0000110;
            default: hexdecode = 7'b0001110;
        endcase
    endfunction

    // Next-state logic for the scan FSM
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (run_q) begin
            unique case (state_q)
                StScan: begin
                    if (cnt_q == CNTW'(REFRESH_DIV - 1)) begin
                        cnt_d   = '0;
                        state_d = StBlank;
                    end else begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end
                StBlank: begin
                    if (cnt_q == CNTW'(BLANK_CYCLES - 1)) begin
                        cnt_d   = '0;
                        state_d = StScan;
                        idx_d   = (idx_q == IDXW'(DIGITS - 1)) ? '0 : idx_q + IDXW'(1);
                    end else begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end
                default: state_d = StScan;
            endcase
        end
    end

    assign nibble = dispValue[{idx_q, 2'b00} +: 4];

`ifdef HEX_DEBUG_DISPLAY_LZB_EN
    // Digit is a leading zero when it and every nibble above it are zero.
    logic [31:0] upper;
    logic        lz_blank;
    assign upper    = dispValue >> {idx_q, 2'b00};
    assign lz_blank = (idx_q != '0) && (upper == '0);
`endif

    // Display outputs, registered below
    always_comb begin
        anodes_d   = '1;
        segments_d = 7'h7F;
        dp_d       = 1'b1;
        if (run_q && state_q == StScan) begin
            anodes_d   = ~(DIGITS'(1) << idx_q);
            segments_d = hexdecode(nibble);
            dp_d       = ~(freeze && idx_q == '0);
`ifdef HEX_DEBUG_DISPLAY_LZB_EN
            if (lz_blank) begin
                segments_d = 7'h7F;
            end
`endif
        end
    end

    always_ff @(posedge sysClk or negedge sysRes) begin
        if (!sysRes) begin
            state_q   <= StScan;
            idx_q     <= '0;
            cnt_q     <= '0;
            run_q     <= 1'b0;
            dispValue <= '0;
            anodes    <= '1;
            segments  <= 7'h7F;
            dp        <= 1'b1;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            run_q    <= 1'b1;
            anodes   <= anodes_d;
            segments <= segments_d;
            dp       <= dp_d;
            if (valueValid && !freeze) begin
                dispValue <= value;
            end
        end
    end

endmodule

// File: tb/tb_hex_debug_display.sv
module tb_hex_debug_display;

    localparam int unsigned DIGITS       = 8;
    localparam int unsigned REFRESH_DIV  = 4;
    localparam int unsigned BLANK_CYCLES = 1;

`ifdef HEX_DEBUG_DISPLAY_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic              sysClk = 1'b0;
    logic              sysRes = 1'b1;
    logic [31:0]       value = '0;
    logic              valueValid = 1'b0;
    logic              freeze = 1'b0;
    logic [31:0]       dispValue;
    logic [DIGITS-1:0] anodes;
    logic [6:0]        segments;
    logic              dp;

    int unsigned checks = 0;
    int unsigned passes = 0;

    hex_debug_display #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) dut (
        .sysClk    (sysClk),
        .sysRes    (sysRes),
        .value     (value),
        .valueValid(valueValid),
        .freeze    (freeze),
        .dispValue (dispValue),
        .anodes    (anodes),
        .segments  (segments),
        .dp        (dp)
    );

    always #5 sysClk = ~sysClk;

    typedef struct {
        logic [31:0] val;
        int          dig;
        logic [6:0]  seg;      // macro off
        logic [6:0]  seg_lzb;  // macro on
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    // Waits for the first cycle in which digit d becomes lit.
    task automatic wait_digit(input int d, output bit ok);
        logic [7:0] tgt;
        tgt = ~(8'(1) << d);
        ok  = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge sysClk);
            if (anodes !== tgt) break;
        end
        for (int i = 0; i < 60; i++) begin
            @(negedge sysClk);
            if (anodes === tgt) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            $display("FAIL wait_digit%0d: timed out, anodes=%0h want %0h", d, anodes, tgt);
        end
    endtask

    task automatic latch(input logic [31:0] v);
        @(negedge sysClk);
        value      = v;
        valueValid = 1'b1;
        @(negedge sysClk);
        valueValid = 1'b0;
    endtask

    initial begin
        bit         ok;
        logic [7:0] exp_an;
        int         p;

        vecs[0]  = '{32'h0000_00A5, 0, 7'b0010010, 7'b0010010};
        vecs[1]  = '{32'h0000_00A5, 1, 7'b0001000, 7'b0001000};
        vecs[2]  = '{32'h0000_00A5, 2, 7'b1000000, 7'h7F};
        vecs[3]  = '{32'h0000_00A5, 7, 7'b1000000, 7'h7F};
        vecs[4]  = '{32'h0000_0000, 0, 7'b1000000, 7'b1000000};
        vecs[5]  = '{32'h0000_0000, 3, 7'b1000000, 7'h7F};
        vecs[6]  = '{32'h89AB_CDEF, 0, 7'b0001110, 7'b0001110};
        vecs[7]  = '{32'h89AB_CDEF, 1, 7'b0000110, 7'b0000110};
        vecs[8]  = '{32'h89AB_CDEF, 2, 7'b0100001, 7'b0100001};
        vecs[9]  = '{32'h89AB_CDEF, 3, 7'b1000110, 7'b1000110};
        vecs[10] = '{32'h89AB_CDEF, 4, 7'b0000011, 7'b0000011};
        vecs[11] = '{32'h89AB_CDEF, 5, 7'b0001000, 7'b0001000};
        vecs[12] = '{32'h89AB_CDEF, 6, 7'b0010000, 7'b0010000};
        vecs[13] = '{32'h89AB_CDEF, 7, 7'b0000000, 7'b0000000};
        vecs[14] = '{32'h0100_0000, 5, 7'b1000000, 7'b1000000};
        vecs[15] = '{32'h0100_0000, 6, 7'b1111001, 7'b1111001};
        vecs[16] = '{32'h0100_0000, 7, 7'b1000000, 7'h7F};
        vecs[17] = '{32'h7654_3210, 2, 7'b0100100, 7'b0100100};
        vecs[18] = '{32'h7654_3210, 3, 7'b0110000, 7'b0110000};
        vecs[19] = '{32'h7654_3210, 7, 7'b1111000, 7'b1111000};

        // Asynchronous reset, before any clock edge
        #1 sysRes = 1'b0;
        #1;
        check("rst_anodes", 32'(anodes), 32'hFF);
        check("rst_segments", 32'(segments), 32'h7F);
        check("rst_dp", 32'(dp), 32'h1);
        check("rst_dispValue", dispValue, 32'h0);

        // Scan order across two frames: digit lit 4 cycles, dark 1 cycle
        @(negedge sysClk);
        @(negedge sysClk);
        sysRes = 1'b1;
        for (int c = 1; c <= 82; c++) begin
            @(negedge sysClk);
            if (c == 1) begin
                exp_an = 8'hFF;
            end else begin
                p      = (c - 2) % 5;
                exp_an = (p < 4) ? ~(8'(1) << (((c - 2) / 5) % 8)) : 8'hFF;
            end
            check($sformatf("scan_c%0d", c), 32'(anodes), 32'(exp_an));
        end

        // Latch and decode table
        foreach (vecs[i]) begin
            latch(vecs[i].val);
            check($sformatf("vec%0d_dispValue", i), dispValue, vecs[i].val);
            wait_digit(vecs[i].dig, ok);
            check($sformatf("vec%0d_seg_d%0d", i, vecs[i].dig), 32'(segments),
                  32'(LZB ? vecs[i].seg_lzb : vecs[i].seg));
            check($sformatf("vec%0d_dp", i), 32'(dp), 32'h1);
        end

        // Latency: dispValue updates at edge k, segments at edge k+1
        latch(32'h0000_00A5);
        wait_digit(0, ok);
        value      = 32'h0000_0007;
        valueValid = 1'b1;
        @(negedge sysClk);
        valueValid = 1'b0;
        check("lat_dispValue_k", dispValue, 32'h7);
        check("lat_segments_k", 32'(segments), 32'(7'b0010010));
        check("lat_anodes_k", 32'(anodes), 32'hFE);
        @(negedge sysClk);
        check("lat_segments_k1", 32'(segments), 32'(7'b1111000));
        check("lat_anodes_k1", 32'(anodes), 32'hFE);

        // Freeze wins over valueValid; DP lit only on digit 0
        latch(32'h0000_00A5);
        @(negedge sysClk);
        freeze     = 1'b1;
        valueValid = 1'b1;
        value      = 32'h0000_1234;
        @(negedge sysClk);
        valueValid = 1'b0;
        check("frz_dispValue", dispValue, 32'hA5);
        wait_digit(0, ok);
        check("frz_dp_d0", 32'(dp), 32'h0);
        for (int i = 0; i < 4; i++) @(negedge sysClk);
        check("frz_blank_anodes", 32'(anodes), 32'hFF);
        check("frz_blank_dp", 32'(dp), 32'h1);
        wait_digit(1, ok);
        check("frz_dp_d1", 32'(dp), 32'h1);
        check("frz_dispValue_hold", dispValue, 32'hA5);
        freeze = 1'b0;
        wait_digit(0, ok);
        check("unfrz_dp_d0", 32'(dp), 32'h1);

        // Reset mid-scan while digit 1 is lit
        wait_digit(1, ok);
        check("mid_anodes_pre", 32'(anodes), 32'hFD);
        #2 sysRes = 1'b0;
        #1;
        check("mid_rst_anodes", 32'(anodes), 32'hFF);
        check("mid_rst_segments", 32'(segments), 32'h7F);
        check("mid_rst_dp", 32'(dp), 32'h1);
        check("mid_rst_dispValue", dispValue, 32'h0);
        @(negedge sysClk);
        @(negedge sysClk);
        check("mid_rst_hold_anodes", 32'(anodes), 32'hFF);
        sysRes = 1'b1;
        @(negedge sysClk);
        check("rel_edge1_anodes", 32'(anodes), 32'hFF);
        @(negedge sysClk);
        check("rel_edge2_anodes", 32'(anodes), 32'hFE);
        check("rel_edge2_segments", 32'(segments), 32'(7'b1000000));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
